// File: rtl/hls8x2_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hls8x2_mul_pipe
// Description : Parametrised pipelined multiplier for the HLS8x2 datapath.
//               It computes the full-width product of two operands, which
//               can be signed or unsigned. An optional right shift with
//               round-half-up is applied. The result then wraps or
//               saturates to the output width, and an overflow flag is
//               raised when it does not fit.
//               Latency is NUM_STAGE ce-qualified clock edges.
//               Throughput is one operand pair per ce cycle.
// Ports       : clk        - clock, all state on rising edge
//               reset      - synchronous active-high reset, priority over ce
//               ce         - pipeline advance enable (stall when low)
//               din_valid  - din0/din1 carry a valid operand pair
//               din0/din1  - operands A / B
//               dout_valid - dout/ovf carry a valid result
//               dout       - shifted, rounded, wrapped/saturated product
//               ovf        - result was outside the dout range
// Revision    : 1.0 - initial release
// ============================================================================
module hls8x2_mul_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 1,
  parameter int SHIFT      = 0,
  parameter int SAT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  // Full product width, and one extra bit so the rounding add cannot carry out.
  localparam int c_w  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int c_rw = c_w + 1;
  // Range-check width: at least one bit wider than both the result and dout.
  // Then both the "fits" test and the truncation are plain slices,
  // whichever of the two is larger.
  localparam int c_xw = ((DOUT_WIDTH > c_rw) ? DOUT_WIDTH : c_rw) + 1;

  localparam logic [DOUT_WIDTH-1:0] c_smin = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] c_smax = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] c_umax = {DOUT_WIDTH{1'b1}};

  // Both operands are extended to the full product width before
  // multiplying. The low c_w bits of the product are then exact for signed
  // and unsigned operands. The most-negative squared case still fits.
  function automatic logic [c_w-1:0] f_mul(input logic [DIN0_WIDTH-1:0] a,
                                           input logic [DIN1_WIDTH-1:0] b);
    logic [c_w-1:0] ea;
    logic [c_w-1:0] eb;
    if (SIGNED != 0) begin
      ea = {{DIN1_WIDTH{a[DIN0_WIDTH-1]}}, a};
      eb = {{DIN0_WIDTH{b[DIN1_WIDTH-1]}}, b};
    end else begin
      ea = {{DIN1_WIDTH{1'b0}}, a};
      eb = {{DIN0_WIDTH{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  // Product and valid entering the final (output) stage.
  logic [c_w-1:0] w_pp;
  logic           w_pv;

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign w_pp = f_mul(din0, din1);
      assign w_pv = din_valid;
    end else begin : g_piped
      logic [DIN0_WIDTH-1:0] r_a;
      logic [DIN1_WIDTH-1:0] r_b;
      logic                  r_av;
      logic [c_w-1:0]        w_prod;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_a  <= '0;
          r_b  <= '0;
          r_av <= 1'b0;
        end else if (ce) begin
          r_a  <= din0;
          r_b  <= din1;
          r_av <= din_valid;
        end
      end

      assign w_prod = f_mul(r_a, r_b);

      if (NUM_STAGE == 2) begin : g_no_prod_reg
        assign w_pp = w_prod;
        assign w_pv = r_av;
      end else begin : g_prod_reg
        // The first entry registers the multiplier output. The rest are
        // balancing registers that retiming can pull into the multiplier.
        localparam int c_np = NUM_STAGE - 2;
        logic [c_w-1:0]  r_p [c_np];
        logic [c_np-1:0] r_pv;

        always_ff @(posedge clk) begin
          if (reset) begin
            for (int i = 0; i < c_np; i++) begin
              r_p[i] <= '0;
            end
            r_pv <= '0;
          end else if (ce) begin
            r_p[0]  <= w_prod;
            r_pv[0] <= r_av;
            for (int i = 1; i < c_np; i++) begin
              r_p[i]  <= r_p[i-1];
              r_pv[i] <= r_pv[i-1];
            end
          end
        end

        assign w_pp = r_p[c_np-1];
        assign w_pv = r_pv[c_np-1];
      end
    end
  endgenerate

  // Post-processing: extend, round, shift.
  logic [c_rw-1:0] w_pe;
  logic [c_rw-1:0] w_r;

  assign w_pe = (SIGNED != 0) ? {w_pp[c_w-1], w_pp} : {1'b0, w_pp};

  generate
    if (SHIFT == 0) begin : g_no_shift
      assign w_r = w_pe;
    end else begin : g_shift
      localparam logic [c_rw-1:0] c_half =
        {{(c_rw-1){1'b0}}, 1'b1} << (SHIFT - 1);
      logic        [c_rw-1:0] w_sum;
      logic signed [c_rw-1:0] w_sum_s;
      logic        [c_rw-1:0] w_sra;
      logic        [c_rw-1:0] w_srl;

      assign w_sum   = w_pe + c_half;
      // The shift is kept in its own signed statement so that it stays
      // arithmetic. A mixed-sign ternary would silently make it logical.
      assign w_sum_s = w_sum;
      assign w_sra   = w_sum_s >>> SHIFT;
      assign w_srl   = w_sum >> SHIFT;
      assign w_r     = (SIGNED != 0) ? w_sra : w_srl;
    end
  endgenerate

  // Range check and wrap/saturate.
  logic [c_xw-1:0]       w_rx;
  logic                  w_fit;
  logic                  w_ovf;
  logic [DOUT_WIDTH-1:0] w_dout;

  always_comb begin
    w_rx  = {{(c_xw-c_rw){(SIGNED != 0) & w_r[c_rw-1]}}, w_r};
    w_fit = 1'b1;
    if (SIGNED != 0) begin
      // Fits when every bit from the dout sign bit upward is identical.
      w_fit = (&w_rx[c_xw-1:DOUT_WIDTH-1]) | ~(|w_rx[c_xw-1:DOUT_WIDTH-1]);
    end else begin
      w_fit = ~(|w_rx[c_xw-1:DOUT_WIDTH]);
    end
    w_ovf  = ~w_fit;
    w_dout = w_rx[DOUT_WIDTH-1:0];
    if ((SAT_MODE != 0) && w_ovf) begin
      if (SIGNED != 0) begin
        w_dout = w_rx[c_xw-1] ? c_smin : c_smax;
      end else begin
        w_dout = c_umax;
      end
    end
  end

  // Output stage.
  logic [DOUT_WIDTH-1:0] r_dout;
  logic                  r_ovf;
  logic                  r_dv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_dv   <= 1'b0;
    end else if (ce) begin
      r_dout <= w_dout;
      r_ovf  <= w_ovf;
      r_dv   <= w_pv;
    end
  end

  assign dout       = r_dout;
  assign ovf        = r_ovf;
  assign dout_valid = r_dv;

endmodule
`default_nettype wire

// File: tb/tb_hls8x2_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hls8x2_mul_pipe
// Description : Directed self-checking bench for hls8x2_mul_pipe.
//               Several configurations share one stimulus bus:
//                 u_wrap - signed 16x16->16, 3 stages, wrap
//                 u_sat  - signed 16x16->16, 3 stages, saturate
//                 u_rnd  - signed 16x16->16, 3 stages, SHIFT=8
//                 u_uns  - unsigned 16x16->16, 3 stages, SHIFT=16, saturate
//                 g_sweep[k].u_sw - signed 16x16->32, NUM_STAGE=k (1..8)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hls8x2_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        din_valid;
  logic [15:0] din0;
  logic [15:0] din1;

  always #5 clk = ~clk;

  logic        dv_w, ovf_w, dv_s, ovf_s, dv_r, ovf_r, dv_u, ovf_u;
  logic [15:0] d_w, d_s, d_r, d_u;
  logic        sw_v [1:8];
  logic        sw_o [1:8];
  logic [31:0] sw_d [1:8];

  hls8x2_mul_pipe #(.NUM_STAGE(3), .SIGNED(1), .SHIFT(0), .SAT_MODE(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(dv_w), .dout(d_w), .ovf(ovf_w));

  hls8x2_mul_pipe #(.NUM_STAGE(3), .SIGNED(1), .SHIFT(0), .SAT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(dv_s), .dout(d_s), .ovf(ovf_s));

  hls8x2_mul_pipe #(.NUM_STAGE(3), .SIGNED(1), .SHIFT(8), .SAT_MODE(0)) u_rnd (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(dv_r), .dout(d_r), .ovf(ovf_r));

  hls8x2_mul_pipe #(.NUM_STAGE(3), .SIGNED(0), .SHIFT(16), .SAT_MODE(1)) u_uns (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(dv_u), .dout(d_u), .ovf(ovf_u));

  generate
    for (genvar k = 1; k <= 8; k++) begin : g_sweep
      hls8x2_mul_pipe #(.DOUT_WIDTH(32), .NUM_STAGE(k), .SIGNED(1), .SHIFT(0), .SAT_MODE(0)) u_sw (
        .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
        .dout_valid(sw_v[k]), .dout(sw_d[k]), .ovf(sw_o[k]));
    end
  endgenerate

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid pair, then two invalid cycles: the 3-stage instances show it.
  task automatic send3(input logic [15:0] a, input logic [15:0] b);
    din0 = a;
    din1 = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
  endtask

  // One valid pair. Sweep instance k must show it exactly at edge k,
  // while instance k+1 still shows the invalid pair ahead of it.
  task automatic sweep_vec(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    din0 = a;
    din1 = b;
    din_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      din_valid = 1'b0;
      chk($sformatf("sw%0d_valid", k), sw_v[k], 1);
      chk($sformatf("sw%0d_dout", k), sw_d[k], exp);
      chk($sformatf("sw%0d_ovf", k), sw_o[k], 0);
      if (k < 8) chk($sformatf("sw%0d_early", k + 1), sw_v[k + 1], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mdl_v [3];
    int          mdl_d [3];
    int          seen;
    int          idx;
    logic [15:0] ra;
    logic [15:0] rb;

    reset = 1'b1; ce = 1'b1; din_valid = 1'b0; din0 = '0; din1 = '0;

    // T1: reset values and latency.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_dv", dv_w, 0);
      chk("rst_dout", d_w, 0);
      chk("rst_ovf", ovf_w, 0);
    end
    reset = 1'b0;
    din0 = 16'd3; din1 = 16'd4; din_valid = 1'b1;
    tick(); chk("t1_edge1_dv", dv_w, 0);
    din_valid = 1'b0;
    tick(); chk("t1_edge2_dv", dv_w, 0);
    tick(); chk("t1_edge3_dv", dv_w, 1);
    chk("t1_dout", d_w, 16'd12);
    chk("t1_ovf", ovf_w, 0);
    tick(); chk("t1_single_pulse", dv_w, 0);

    // T2: wrap vs saturate.
    send3(16'd300, 16'hFF38);                 // 300 * -200 = -60000
    chk("t2_wrap_neg", d_w, 16'h15A0); chk("t2_wrap_neg_ovf", ovf_w, 1);
    chk("t2_sat_neg", d_s, 16'h8000);  chk("t2_sat_neg_ovf", ovf_s, 1);
    send3(16'd100, 16'hFF38);                 // 100 * -200 = -20000
    chk("t2_wrap_fit", d_w, 16'hB1E0); chk("t2_wrap_fit_ovf", ovf_w, 0);
    chk("t2_sat_fit", d_s, 16'hB1E0);  chk("t2_sat_fit_ovf", ovf_s, 0);
    send3(16'd300, 16'd200);                  // 60000
    chk("t2_wrap_pos", d_w, 16'hEA60); chk("t2_wrap_pos_ovf", ovf_w, 1);
    chk("t2_sat_pos", d_s, 16'h7FFF);  chk("t2_sat_pos_ovf", ovf_s, 1);

    // T3: rounding right shift.
    send3(16'd3, 16'd100);    chk("t3_300", d_r, 16'h0001); chk("t3_300_ovf", ovf_r, 0);
    send3(16'hFFFD, 16'd100); chk("t3_m300", d_r, 16'hFFFF); chk("t3_m300_ovf", ovf_r, 0);
    send3(16'd1, 16'd128);    chk("t3_half_up", d_r, 16'h0001);
    send3(16'd1, 16'd127);    chk("t3_below_half", d_r, 16'h0000);
    send3(16'd30000, 16'd30000);
    chk("t3_big_wrap", d_r, 16'hA4E9); chk("t3_big_ovf", ovf_r, 1);
    send3(16'hFFFF, 16'hFFFF);
    chk("t3_uns_max", d_u, 16'hFFFE); chk("t3_uns_ovf", ovf_u, 0);
    chk("t3_uns_dv", dv_u, 1);
    chk("t3_sgn_m1sq", d_r, 16'h0000); chk("t3_sgn_m1sq_ovf", ovf_r, 0);

    // T4: stall mid-stream.
    // The reference is an ideal 3-deep pipeline that moves only on ce.
    for (int i = 0; i < 3; i++) begin
      mdl_v[i] = 0;
      mdl_d[i] = 0;
    end
    seen = 0;
    idx  = 0;
    for (int c = 0; c < 14; c++) begin
      ce = !(c >= 3 && c < 6);
      if (ce) begin
        if (idx < 6) begin
          din0 = 16'(idx + 1); din1 = 16'd2; din_valid = 1'b1; idx++;
        end else begin
          din_valid = 1'b0;
        end
        mdl_v[2] = mdl_v[1]; mdl_d[2] = mdl_d[1];
        mdl_v[1] = mdl_v[0]; mdl_d[1] = mdl_d[0];
        mdl_v[0] = int'(din_valid); mdl_d[0] = int'(din0) * int'(din1);
      end
      tick();
      chk($sformatf("t4_dv_c%0d", c), dv_w, mdl_v[2]);
      if (mdl_v[2] != 0) begin
        chk($sformatf("t4_dout_c%0d", c), d_w, mdl_d[2]);
        if (ce) begin
          seen++;
          chk($sformatf("t4_order_%0d", seen), d_w, 2 * seen);
        end
      end
    end
    chk("t4_count", seen, 6);
    ce = 1'b1;
    din_valid = 1'b0;

    // T5: reset while pairs are in flight.
    din_valid = 1'b1;
    din0 = 16'd7; din1 = 16'd1; tick();
    din0 = 16'd8;               tick();
    din0 = 16'd9;               tick();
    chk("t5_first_out", d_w, 16'd7);
    din_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_rst_dv", dv_w, 0); chk("t5_rst_dout", d_w, 0); chk("t5_rst_ovf", ovf_w, 0);
    reset = 1'b0;
    din0 = 16'd5; din1 = 16'd5; din_valid = 1'b1;
    tick(); chk("t5_post1_dv", dv_w, 0);
    din_valid = 1'b0;
    tick(); chk("t5_post2_dv", dv_w, 0);
    tick(); chk("t5_post3_dv", dv_w, 1); chk("t5_dout", d_w, 16'd25);

    // T6: corner case plus NUM_STAGE sweep.
    tick();
    sweep_vec(16'h8000, 16'h8000, 32'h4000_0000);
    sweep_vec(16'h7FFF, 16'h8000, 32'hC000_8000);
    sweep_vec(16'h1234, 16'h0010, 32'h0001_2340);
    sweep_vec(16'hFFFF, 16'h0005, 32'hFFFF_FFFB);
    for (int r = 0; r < 4; r++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      sweep_vec(ra, rb, 32'(int'($signed(ra)) * int'($signed(rb))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
